// File: rtl/dmem_bridge.sv
// dmem_bridge: connects the core's memory-stage port to the single-port data bus.
// Stores are posted into a small write FIFO and drained onto the bus in order.
// Loads wait until every earlier posted store has completed on the bus.
//
// Handshakes:
//   Bus:  a transfer completes in the cycle where bus_req and bus_ack are both
//         high. While bus_req is high, bus_we/bus_addr/bus_wdata/bus_be stay
//         stable. bus_req never depends combinationally on bus_ack.
//   Core: a store is a single-cycle core_we pulse. It is never back-pressured;
//         when it cannot be queued it is dropped and reported.
//         A load holds core_re and core_addr until the one-cycle core_rvalid.
module dmem_bridge #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic        core_we,
  input  logic [3:0]  core_wmask,
  input  logic        core_re,
  output logic [31:0] core_rdata,
  output logic        core_rvalid,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        misalign_err,
  output logic        wr_overflow,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } entry_t;

  state_t        state;
  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr_inc;
  logic [AW:0]   count;
  logic [AW:0]   count_next;

  logic [1:0]    off;
  logic          st_mis;
  logic          ld_mis;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          full;
  logic          overflow_hit;
  entry_t        push_entry;
  entry_t        head_after_pop;

  // Decode store/load alignment and FIFO push/pop decisions for this cycle.
  always_comb begin
    off            = core_addr[1:0];
    st_mis         = ((core_wmask == 4'b0011) && off[0]) ||
                     ((core_wmask == 4'b1111) && (off != 2'b00));
    ld_mis         = (core_wmask == 4'b1111) && (off != 2'b00);
    push_entry     = '0;
    push_entry.addr  = {core_addr[31:2], 2'b00};
    push_entry.wdata = core_wdata << {off, 3'b000};
    push_entry.be    = core_wmask << off;
    pop            = (state == S_WR) && bus_ack;
    full           = (count == (AW+1)'(DEPTH));
    push_req       = core_we && !st_mis;
    push           = push_req && (!full || pop);
    overflow_hit   = push_req && full && !pop;
    rd_ptr_inc     = rd_ptr + AW'(1);
    count_next     = count;
    case ({push, pop})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
    // Entry presented on the bus after a pop: the next stored entry, or the
    // store being pushed right now when the FIFO held only the popped one.
    head_after_pop = (count >= (AW+1)'(2)) ? mem[rd_ptr_inc] : push_entry;
  end

  // FIFO storage and pointers; the count changes only on push xor pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      count <= count_next;
    end
  end

  // Bus sequencing FSM with registered bus and core-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_be       <= '0;
      core_rdata   <= '0;
      core_rvalid  <= 1'b0;
      misalign_err <= 1'b0;
      wr_overflow  <= 1'b0;
    end else begin
      misalign_err <= core_we && st_mis;
      core_rvalid  <= 1'b0;
      if (overflow_hit) begin
        wr_overflow <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if ((count != '0) || push) begin
            // Stores go out before any load seen in the same cycle.
            state     <= S_WR;
            bus_req   <= 1'b1;
            bus_we    <= 1'b1;
            bus_addr  <= (count != '0) ? mem[rd_ptr].addr  : push_entry.addr;
            bus_wdata <= (count != '0) ? mem[rd_ptr].wdata : push_entry.wdata;
            bus_be    <= (count != '0) ? mem[rd_ptr].be    : push_entry.be;
          end else if (core_re) begin
            if (ld_mis) begin
              misalign_err <= 1'b1;
              core_rdata   <= '0;
              core_rvalid  <= 1'b1;
              state        <= S_RESP;
            end else begin
              state     <= S_RD;
              bus_req   <= 1'b1;
              bus_we    <= 1'b0;
              bus_addr  <= {core_addr[31:2], 2'b00};
              bus_wdata <= '0;
              bus_be    <= 4'b1111;
            end
          end
        end
        S_WR: begin
          if (bus_ack) begin
            if (count_next == '0) begin
              state   <= S_IDLE;
              bus_req <= 1'b0;
              bus_we  <= 1'b0;
            end else begin
              bus_addr  <= head_after_pop.addr;
              bus_wdata <= head_after_pop.wdata;
              bus_be    <= head_after_pop.be;
            end
          end
        end
        S_RD: begin
          if (bus_ack) begin
            core_rdata  <= bus_rdata >> {off, 3'b000};
            core_rvalid <= 1'b1;
            bus_req     <= 1'b0;
            state       <= S_RESP;
          end
        end
        S_RESP: begin
          // core_re still belongs to the load just completed.
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (count != '0) || (state != S_IDLE);
  assign state_dbg = state;

endmodule
